iir_biquad_cascade: RTL and testbench
=====================================

// Module: iir_biquad_cascade
// PURPOSE
//  Parametrised cascade of NUM_SECT direct-form-I biquad IIR sections sharing one multiplier (time-multiplexed).
//  Successor to the fixed single-biquad filter: adds runtime-programmable coefficients, valid/ready input,
//  rounding, per-section saturation and a clear. Sits between the sample source and downstream DSP.
// PARAMETERS
//  DATA_W    12  sample width (signed), also stored x/y history width
//  COEF_W     8  coefficient width (signed)
//  COEF_FRAC  6  coefficient fractional bits (1.0 = 1<<COEF_FRAC)
//  NUM_SECT   2  number of cascaded biquad sections (1..8)
//  ACC_W     32  accumulator width; must be >= DATA_W+COEF_W+3
// PORTS
//  clk        in   1                 clock, rising edge
//  rst_n      in   1                 async active-low reset
//  in_valid   in   1                 din valid
//  in_ready   out  1                 block can accept a sample (IDLE)
//  din        in   DATA_W            input sample, signed
//  out_valid  out  1                 one-cycle pulse, dout valid
//  dout       out  DATA_W            filtered sample, signed
//  out_sat    out  1                 any section saturated for this sample; valid with out_valid
//  clear      in   1                 sync: zero all history, abort in-flight sample
//  coef_we    in   1                 coefficient write strobe
//  coef_sect  in   $clog2(NUM_SECT)+1 target section (out-of-range: write ignored)
//  coef_idx   in   3                 0=b0 1=b1 2=b2 3=a1 4=a2 (5..7 ignored)
//  coef_data  in   COEF_W            coefficient value, signed
// BEHAVIOUR
//  Per section s: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2; section s output feeds section s+1 as x.
//  Reset: in_ready=1 after reset, out_valid=0, dout=0, out_sat=0, all history=0,
//   coefs per section b0=1<<COEF_FRAC, others 0 (pass-through). Reset mid-operation aborts immediately.
//  FSM: IDLE -> MAC -> STORE -> (MAC next section | IDLE).
//   IDLE: in_ready=1; in_valid&in_ready at edge k latches din, sect=0, acc=0, go MAC.
//   MAC: 5 cycles, one product per cycle in order b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2, acc += product.
//   STORE: r = (acc + (1<<(COEF_FRAC-1))) >>> COEF_FRAC (round half toward +inf); saturate r to
//    [-2^(DATA_W-1), 2^(DATA_W-1)-1]; set sat bit if clipped; x2<=x1, x1<=x, y2<=y1, y1<=sat(r);
//    sat(r) becomes next section's x. Last section: dout<=sat(r), out_sat<=OR of section sat bits,
//    out_valid<=1 (visible after edge k+6*NUM_SECT), go IDLE.
//  Latency 6*NUM_SECT edges accept->out_valid; max throughput 1 sample per 6*NUM_SECT+1 cycles.
//  out_valid has no backpressure; it is high exactly one cycle per accepted sample.
//  History stored saturated at DATA_W; accumulator never wraps for legal ACC_W.
//  clear (priority over in_valid and coef_we): next edge zeroes history of all sections, returns to IDLE,
//   no out_valid for the aborted sample; coefficients untouched.
//  coef_we applied only when in_ready=1 (takes effect for next accepted sample); dropped when in_ready=0.
//  coef_we and in_valid accepted in same IDLE cycle: the sample uses the NEW coefficient.
// TESTING
//  T1 reset, default coefs, NUM_SECT=2: din=100 accepted at edge k -> out_valid at k+12, dout=100, out_sat=0.
//  T2 sect0 = b{5,9,5} a1=-71 a2=25, sect1 pass-through; impulse 1000 then zeros -> dout 78, then 227.
//  T3 sect0 b0=127: din=2047 -> dout=2047 out_sat=1; din=-2048 -> dout=-2048 out_sat=1.
//  T4 in_valid held high with ramp data -> accepts every 13 cycles, in_ready low while busy, no sample lost.
//  T5 clear asserted mid-MAC -> no out_valid; next din=100 with defaults -> dout=100 (history zeroed).
//  T6 coef_we while in_ready=0 -> dropped (readback via pass-through output unchanged); rst_n low mid-op ->
//     outputs/coefs return to reset values asynchronously.

Source files
------------

// File: rtl/iir_biquad_cascade.sv
// Cascade of NUM_SECT direct-form-I biquads that share one multiplier. Each section takes
// 5 MAC cycles plus 1 STORE cycle, so one sample needs 6*NUM_SECT cycles.
module iir_biquad_cascade #(
    parameter int DATA_W    = 12,
    parameter int COEF_W    = 8,
    parameter int COEF_FRAC = 6,
    parameter int NUM_SECT  = 2,
    parameter int ACC_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      din,
    output logic                          out_valid,
    output logic signed [DATA_W-1:0]      dout,
    output logic                          out_sat,
    input  logic                          clear,
    input  logic                          coef_we,
    input  logic [$clog2(NUM_SECT):0]     coef_sect,
    input  logic [2:0]                    coef_idx,
    input  logic signed [COEF_W-1:0]      coef_data
);

    localparam int SECT_W   = $clog2(NUM_SECT) + 1;
    localparam int PROD_W   = DATA_W + COEF_W;
    localparam int NUM_COEF = 5;

    localparam logic [2:0]               LAST_STEP = 3'd4;
    localparam logic [SECT_W-1:0]        LAST_SECT = SECT_W'(NUM_SECT - 1);
    localparam logic signed [COEF_W-1:0] UNITY     = COEF_W'(1 << COEF_FRAC);
    localparam logic signed [ACC_W-1:0]  RND_HALF  = ACC_W'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX   = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN   = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        STORE
    } state_t;

    state_t state, state_next;

    // Coefficient order per section: b0, b1, b2, a1, a2.
    logic signed [COEF_W-1:0] coef [NUM_SECT][NUM_COEF];
    logic signed [DATA_W-1:0] x1 [NUM_SECT];
    logic signed [DATA_W-1:0] x2 [NUM_SECT];
    logic signed [DATA_W-1:0] y1 [NUM_SECT];
    logic signed [DATA_W-1:0] y2 [NUM_SECT];

    logic signed [DATA_W-1:0] cur_x;
    logic signed [ACC_W-1:0]  acc;
    logic [2:0]               step;
    logic [SECT_W-1:0]        sect;
    logic                     sat_any;

    logic signed [COEF_W-1:0] sel_coef;
    logic signed [DATA_W-1:0] sel_data;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [DATA_W-1:0] sat_val;
    logic                     clip;
    logic                     last_sect;
    logic                     accept;
    logic                     coef_wr;

    assign last_sect = (sect == LAST_SECT);
    assign accept    = (state == IDLE) && in_valid && !clear;
    assign coef_wr   = (state == IDLE) && coef_we && !clear;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        case (state)
            IDLE:    if (in_valid) state_next = MAC;
            MAC:     if (step == LAST_STEP) state_next = STORE;
            STORE:   state_next = last_sect ? IDLE : MAC;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------ shared multiplier path
    always_comb begin
        sel_coef = '0;
        sel_data = '0;
        for (int s = 0; s < NUM_SECT; s++) begin
            if (sect == SECT_W'(s)) begin
                case (step)
                    3'd0:    begin sel_coef = coef[s][0]; sel_data = cur_x; end
                    3'd1:    begin sel_coef = coef[s][1]; sel_data = x1[s]; end
                    3'd2:    begin sel_coef = coef[s][2]; sel_data = x2[s]; end
                    3'd3:    begin sel_coef = coef[s][3]; sel_data = y1[s]; end
                    3'd4:    begin sel_coef = coef[s][4]; sel_data = y2[s]; end
                    default: begin sel_coef = '0;         sel_data = '0;    end
                endcase
            end
        end
    end

    assign prod = PROD_W'(sel_coef) * PROD_W'(sel_data);

    // Feedback terms (a1, a2) are subtracted.
    assign acc_next = (step >= 3'd3) ? acc - ACC_W'(prod) : acc + ACC_W'(prod);

    // Round half toward +inf, then clip to the sample range.
    assign acc_rnd = acc + RND_HALF;
    assign rnd     = acc_rnd >>> COEF_FRAC;

    always_comb begin
        clip    = 1'b0;
        sat_val = rnd[DATA_W-1:0];
        if (rnd > SAT_MAX) begin
            clip    = 1'b1;
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (rnd < SAT_MIN) begin
            clip    = 1'b1;
            sat_val = SAT_MIN[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------ datapath
    // NOTE: coefficients and history are small flop banks, not RAM, so they take the async reset;
    // that is what restores the pass-through coefficient set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x     <= '0;
            acc       <= '0;
            step      <= '0;
            sect      <= '0;
            sat_any   <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_sat   <= 1'b0;
            for (int s = 0; s < NUM_SECT; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
                coef[s][0] <= UNITY;
                for (int i = 1; i < NUM_COEF; i++) begin
                    coef[s][i] <= '0;
                end
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            out_valid <= 1'b0;

            for (int s = 0; s < NUM_SECT; s++) begin
                for (int i = 0; i < NUM_COEF; i++) begin
                    if (coef_wr && coef_sect == SECT_W'(s) && coef_idx == 3'(i)) begin
                        coef[s][i] <= coef_data;
                    end
                end
            end

            if (clear) begin
                acc     <= '0;
                step    <= '0;
                sect    <= '0;
                sat_any <= 1'b0;
                for (int s = 0; s < NUM_SECT; s++) begin
                    x1[s] <= '0;
                    x2[s] <= '0;
                    y1[s] <= '0;
                    y2[s] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            cur_x   <= din;
                            acc     <= '0;
                            step    <= '0;
                            sect    <= '0;
                            sat_any <= 1'b0;
                        end
                    end
                    MAC: begin
                        acc  <= acc_next;
                        step <= (step == LAST_STEP) ? 3'd0 : step + 3'd1;
                    end
                    STORE: begin
                        for (int s = 0; s < NUM_SECT; s++) begin
                            if (sect == SECT_W'(s)) begin
                                x2[s] <= x1[s];
                                x1[s] <= cur_x;
                                y2[s] <= y1[s];
                                y1[s] <= sat_val;
                            end
                        end
                        cur_x   <= sat_val;
                        acc     <= '0;
                        step    <= '0;
                        sat_any <= sat_any | clip;
                        if (last_sect) begin
                            dout      <= sat_val;
                            out_sat   <= sat_any | clip;
                            out_valid <= 1'b1;
                            sect      <= '0;
                        end else begin
                            sect <= sect + SECT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed bench for iir_biquad_cascade (NUM_SECT=2): vector table on pass-through coefficients
// plus hand-computed sequences for filtering, saturation, rounding, throughput, clear and reset.
module tb_iir_biquad_cascade;

    localparam int DATA_W    = 12;
    localparam int COEF_W    = 8;
    localparam int COEF_FRAC = 6;
    localparam int NUM_SECT  = 2;
    localparam int ACC_W     = 32;
    localparam int SW        = $clog2(NUM_SECT) + 1;
    localparam int LAT       = 6 * NUM_SECT;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] din;
    logic                     out_valid;
    logic signed [DATA_W-1:0] dout;
    logic                     out_sat;
    logic                     clear;
    logic                     coef_we;
    logic [SW-1:0]            coef_sect;
    logic [2:0]               coef_idx;
    logic signed [COEF_W-1:0] coef_data;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int    din;
        int    dout;
        int    sat;
        string name;
    } vec_t;

    iir_biquad_cascade #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .COEF_FRAC(COEF_FRAC),
        .NUM_SECT (NUM_SECT),
        .ACC_W    (ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .out_valid(out_valid),
        .dout     (dout),
        .out_sat  (out_sat),
        .clear    (clear),
        .coef_we  (coef_we),
        .coef_sect(coef_sect),
        .coef_idx (coef_idx),
        .coef_data(coef_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", int'(in_ready), 1);
    endtask

    task automatic coef_write(input int sect, input int idx, input int val);
        coef_we   = 1'b1;
        coef_sect = SW'(sect);
        coef_idx  = 3'(idx);
        coef_data = COEF_W'(val);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Accept one sample, wait for its result, check latency, value, sat flag and pulse width.
    task automatic run_sample(input int d, input int exp_d, input int exp_s, input string name);
        int t_acc;
        int n;
        wait_ready();
        in_valid = 1'b1;
        din      = DATA_W'(d);
        t_acc    = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_lat"}, cyc - t_acc, LAT);
        check({name, "_dout"}, int'(dout), exp_d);
        check({name, "_sat"}, int'(out_sat), exp_s);
        @(negedge clk);
        check({name, "_pulse"}, int'(out_valid), 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   ramp[4];
        int   n_acc;
        int   n_out;
        int   last_acc;
        int   budget;
        int   seen;

        vecs[0] = '{100,   100,   0, "pass_100"};
        vecs[1] = '{-100,  -100,  0, "pass_m100"};
        vecs[2] = '{0,     0,     0, "pass_0"};
        vecs[3] = '{1,     1,     0, "pass_1"};
        vecs[4] = '{-1,    -1,    0, "pass_m1"};
        vecs[5] = '{2047,  2047,  0, "pass_max"};
        vecs[6] = '{-2048, -2048, 0, "pass_min"};
        ramp    = '{10, -20, 300, -400};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din       = '0;
        clear     = 1'b0;
        coef_we   = 1'b0;
        coef_sect = '0;
        coef_idx  = '0;
        coef_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_ready", int'(in_ready), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_sat", int'(out_sat), 0);

        // Default coefficients are pass-through in both sections.
        for (int i = 0; i < 7; i++) begin
            run_sample(vecs[i].din, vecs[i].dout, vecs[i].sat, vecs[i].name);
        end

        // Coefficient write in the same cycle as acceptance: sect1 b0=0.5 applies to this sample.
        wait_ready();
        coef_we   = 1'b1;
        coef_sect = SW'(1);
        coef_idx  = 3'd0;
        coef_data = COEF_W'(32);
        run_sample(100, 50, 0, "same_cycle_coef");
        coef_write(1, 0, 64);

        // Out-of-range section and index writes are ignored.
        coef_write(2, 0, 0);
        coef_write(3, 0, 0);
        coef_write(0, 5, 0);
        coef_write(1, 7, 0);
        run_sample(100, 100, 0, "ignored_writes");

        // Resonant section 0, impulse response.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        coef_write(0, 0, 5);
        coef_write(0, 1, 9);
        coef_write(0, 2, 5);
        coef_write(0, 3, -71);
        coef_write(0, 4, 25);
        run_sample(1000, 78, 0, "imp0");
        run_sample(0, 227, 0, "imp1");
        run_sample(0, 299, 0, "imp2");

        // Clear mid-MAC aborts the sample and zeroes history.
        wait_ready();
        in_valid = 1'b1;
        din      = '0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_ready", int'(in_ready), 1);
        seen = 0;
        repeat (20) begin
            if (out_valid) seen = 1;
            @(negedge clk);
        end
        check("clr_no_valid", seen, 0);
        run_sample(1000, 78, 0, "clr_imp0");

        // Section 0 gain ~2: saturation at both rails.
        coef_write(0, 0, 127);
        coef_write(0, 1, 0);
        coef_write(0, 2, 0);
        coef_write(0, 3, 0);
        coef_write(0, 4, 0);
        run_sample(2047, 2047, 1, "sat_pos");
        run_sample(-2048, -2048, 1, "sat_neg");
        run_sample(10, 20, 0, "gain_nosat");

        // Gain 1.5: half-way results round toward +inf.
        coef_write(0, 0, 96);
        run_sample(1, 2, 0, "rnd_pos_half");
        run_sample(-1, -1, 0, "rnd_neg_half");
        coef_write(0, 0, 64);

        // in_valid held high with ramp data: one acceptance every LAT+1 cycles, nothing lost.
        n_acc    = 0;
        n_out    = 0;
        last_acc = 0;
        budget   = 0;
        wait_ready();
        while (n_out < 4 && budget < 200) begin
            in_valid = (n_acc < 4);
            if (n_acc < 4) din = DATA_W'(ramp[n_acc]);
            if (out_valid) begin
                check("ramp_dout", int'(dout), ramp[n_out]);
                n_out++;
            end
            if (in_valid && in_ready) begin
                if (n_acc > 0) check("ramp_gap", cyc - last_acc, LAT + 1);
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        check("ramp_count", n_out, 4);

        // Coefficient write while busy is dropped.
        wait_ready();
        in_valid = 1'b1;
        din      = DATA_W'(100);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("busy_ready_low", int'(in_ready), 0);
        coef_write(0, 0, 0);
        run_sample(100, 100, 0, "busy_write_dropped");

        // Async reset mid-operation restores outputs and coefficients.
        coef_write(0, 0, 127);
        wait_ready();
        in_valid = 1'b1;
        din      = DATA_W'(100);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_ready", int'(in_ready), 1);
        check("arst_valid", int'(out_valid), 0);
        check("arst_dout", int'(dout), 0);
        check("arst_sat", int'(out_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sample(100, 100, 0, "post_rst_coefs");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
